// File: rtl/if_fetch_unit_pkg.sv
// Shared FSM encoding and reset defaults for the instruction fetch unit.
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_VALID = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP           = 32'd4;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction fetch: issues word fetches to imem and presents one instruction at a time to the IF register.
// Latency: ack edge -> instruction valid next cycle; zero-wait memory yields one instruction per 2 cycles.
// Backpressure: freeze holds a presented word and blocks the next fetch; branch_taken overrides freeze.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] instruction,
    output logic        inst_valid
);

    fetch_state_t state;
    fetch_state_t next_state;
    logic [31:0]  pc_reg;
    logic [31:0]  pc_next;
    logic [31:0]  fetch_addr;
    logic [31:0]  inst_buf;
    logic [31:0]  pc_out;
    logic [31:0]  br_tgt;
    logic         buf_load;

    assign br_tgt = branch_addr & ~32'd3;

    always_comb begin
        next_state = state;
        pc_next    = pc_reg;
        buf_load   = 1'b0;
        case (state)
            ST_IDLE: begin
                next_state = ST_REQ;
                if (branch_taken) pc_next = br_tgt;
            end
            ST_REQ: begin
                if (branch_taken) begin
                    pc_next    = br_tgt;
                    next_state = imem_ack ? ST_REQ : ST_DRAIN;
                end else if (imem_ack) begin
                    buf_load   = 1'b1;
                    pc_next    = pc_reg + PC_STEP;
                    next_state = ST_VALID;
                end
            end
            ST_VALID: begin
                if (branch_taken) begin
                    pc_next    = br_tgt;
                    next_state = ST_REQ;
                end else if (!freeze) begin
                    next_state = ST_REQ;
                end
            end
            ST_DRAIN: begin
                // The stale word still has to come back before a new fetch may start.
                if (branch_taken) pc_next = br_tgt;
                if (imem_ack) next_state = ST_REQ;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            pc_reg     <= RESET_PC;
            fetch_addr <= RESET_PC;
            inst_buf   <= NOP_INSTR;
            pc_out     <= RESET_PC;
        end else begin
            state  <= next_state;
            pc_reg <= pc_next;
            if (next_state == ST_REQ) fetch_addr <= pc_next;
            if (buf_load) begin
                inst_buf <= imem_rdata;
                pc_out   <= pc_next;
            end
        end
    end

    // pc_out only moves on an accepted word, so PC keeps its last value outside VALID.
    assign imem_req    = (state == ST_REQ) || (state == ST_DRAIN);
    assign imem_addr   = fetch_addr;
    assign inst_valid  = (state == ST_VALID);
    assign instruction = inst_valid ? inst_buf : NOP_INSTR;
    assign PC          = pc_out;

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000: instruction value driven when no valid instruction is presented.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 freeze  input  1  downstream hazard stall; 1 = IF stage register is not accepting.
REQ-006 branch_taken  input  1  redirect request from the branch-resolving stage.
REQ-007 branch_addr  input  32  redirect target; bits [1:0] treated as 2'b00.
REQ-008 imem_req  output  1  instruction-memory request, held high until imem_ack.
REQ-009 imem_addr  output  32  word-aligned fetch address, stable while imem_req=1.
REQ-010 imem_ack  input  1  one-cycle pulse: imem_rdata valid this cycle, request complete.
REQ-011 imem_rdata  input  32  fetched instruction word.
REQ-012 PC  output  32  address of presented instruction + 4; feeds the IF stage register's PC_in.
REQ-013 instruction  output  32  presented instruction; feeds the IF stage register's instruction_in.
REQ-014 inst_valid  output  1  1 = PC/instruction hold a real fetched instruction.

Function
REQ-015 The block SHALL keep pc_reg (next fetch address), fetch_addr (in-flight address) and inst_buf, all 32-bit.
REQ-016 FSM states SHALL be IDLE, REQ, VALID, DRAIN; the reset state is IDLE.
REQ-017 IDLE: imem_req=0; next state REQ unconditionally (one cycle after reset release).
REQ-018 On entry to REQ, fetch_addr SHALL load pc_reg; in REQ imem_req=1 and imem_addr=fetch_addr.
REQ-019 REQ with imem_ack=1 and branch_taken=0: inst_buf<=imem_rdata, pc_reg<=pc_reg+4, next state VALID.
REQ-020 REQ with branch_taken=1 and imem_ack=1: data discarded, pc_reg<=branch_addr, next state REQ (new fetch).
REQ-021 REQ with branch_taken=1 and imem_ack=0: pc_reg<=branch_addr, next state DRAIN.
REQ-022 DRAIN: imem_req=1 with unchanged fetch_addr; on imem_ack, data discarded, next state REQ; a further branch_taken in DRAIN only updates pc_reg.
REQ-023 VALID: inst_valid=1, instruction=inst_buf, PC=pc_reg; with freeze=0 the word is consumed this edge and next state REQ; with freeze=1 the state and outputs hold.
REQ-024 VALID with branch_taken=1: inst_buf discarded, pc_reg<=branch_addr, next state REQ; branch_taken SHALL take priority over freeze in every state.
REQ-025 Outside VALID: inst_valid=0, instruction=NOP_INSTR, PC holds its last value.
REQ-026 pc_reg+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-027 imem_ack received in IDLE or VALID SHALL be ignored.
REQ-028 Minimum throughput: one instruction per 2 cycles with zero-wait memory (REQ, VALID alternating).

Reset
REQ-029 rst=0 SHALL asynchronously force state=IDLE, pc_reg=RESET_PC, fetch_addr=RESET_PC, inst_buf=NOP_INSTR, hence imem_req=0, inst_valid=0, instruction=NOP_INSTR, PC=RESET_PC.
REQ-030 Reset during an outstanding request SHALL abandon it without draining; the memory side tolerates a dropped imem_req.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (2-bit), NOP_INSTR default and RESET_PC default.
REQ-032 Single module, no sub-module; the PC incrementer and FSM are inline.

Verification
REQ-033 Reset release, imem_ack returned the cycle after each req, rdata=32'hA, 32'hB -> imem_addr 0 then 4; outputs (PC=4,instr=A), then (PC=8,instr=B), inst_valid alternating.
REQ-034 freeze=1 for 3 cycles while VALID with instr 32'hA -> PC/instruction/inst_valid stable 3 cycles, no new imem_req until freeze=0.
REQ-035 branch_taken with branch_addr=32'h40 while REQ outstanding (ack 3 cycles later) -> DRAIN keeps imem_addr unchanged, discarded word never valid, next imem_addr=32'h40.
REQ-036 branch_taken and imem_ack same cycle, branch_addr=32'h100 -> no inst_valid for that word, next imem_addr=32'h100.
REQ-037 pc at 32'hFFFF_FFFC, ack -> PC output 32'h0, next imem_addr 32'h0.
REQ-038 rst asserted mid-REQ -> imem_req and inst_valid drop same cycle without a clock edge; after release the first imem_addr is RESET_PC.
